// File: rtl/record_serializer.sv
// Record-to-beat serializer: captures one {r, th, lanes} record per handshake
// and replays it as NLANES+1 64-bit beats, header first, then lanes high to low.
module record_serializer #(
  parameter int NLANES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_hdr_r,
  input  logic [31:0]           in_hdr_th,
  input  logic [NLANES*64-1:0]  in_lanes,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic                  out_last,
  output logic [CNT_W-1:0]      rec_count,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = 4;

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends combinationally on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_LANE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic [63:0]           r_hdr;
  logic [NLANES*64-1:0]  r_lanes;
  logic                  w_accept;
  logic                  w_done;

  assign dbg_state = r_state;
  assign w_accept  = in_valid && in_ready;
  assign w_done    = (r_state == S_LANE) && (r_idx == '0) && out_ready;

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_HDR;
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = r_hdr;
        if (out_ready) begin
          w_next     = S_LANE;
          w_idx_next = IDX_W'(NLANES - 1);
        end
      end
      S_LANE: begin
        out_valid = 1'b1;
        out_data  = r_lanes[int'(r_idx)*64 +: 64];
        out_last  = (r_idx == '0);
        if (out_ready) begin
          if (r_idx != '0) begin
            w_idx_next = r_idx - IDX_W'(1);
          end else begin
            // Last beat leaving frees the holding register for a same-cycle refill.
            in_ready = 1'b1;
            w_next   = in_valid ? S_HDR : S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_hdr     <= '0;
      r_lanes   <= '0;
      rec_count <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      if (w_accept) begin
        r_hdr   <= {in_hdr_r, in_hdr_th};
        r_lanes <= in_lanes;
      end
      if (w_done) rec_count <= rec_count + CNT_W'(1);
    end
  end

endmodule
